// File: rtl/max_reduce_ctrl.sv
// max_reduce_ctrl: sequences one unsigned compare-and-select per accepted
// operand against a running maximum, then holds {max, first index} on a
// valid/ready result port until the consumer takes it.
module max_reduce_ctrl #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_max,
  output logic [COUNT_W-1:0] out_idx,
  output logic               out_empty,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] len_q, cnt_q, idx_q;
  logic [WIDTH-1:0]   max_q;
  logic               empty_q;
  logic               accept, last, take;

  // len_q is never 0 while in RUN, so len_q-1 cannot underflow there
  assign accept = (state == RUN) && in_valid;
  assign last   = (cnt_q == len_q - COUNT_W'(1));
  assign take   = (state == DONE) && out_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: start only matters in IDLE; stalls simply hold RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:  if (accept && last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // running max datapath: first operand loads unconditionally, later ones
  // replace only on strict greater-than so ties keep the earlier index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      empty_q <= 1'b0;
    end else if (state == IDLE && start) begin
      len_q   <= len;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      empty_q <= (len == '0);
    end else if (accept) begin
      if (!last) cnt_q <= cnt_q + COUNT_W'(1);
      if (cnt_q == '0 || in_data > max_q) begin
        max_q <= in_data;
        idx_q <= cnt_q;
      end
    end else if (take) begin
      empty_q <= 1'b0;
    end
  end

  // outputs come straight from registers and decoded state
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_empty = empty_q;

endmodule

// File: tb/tb_max_reduce_ctrl.sv
// tb_max_reduce_ctrl: directed and randomized jobs against a plain
// max/first-index reference model.
module tb_max_reduce_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] len = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, out_empty, busy;
  logic [W-1:0]  out_max;
  logic [CW-1:0] out_idx;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  max_reduce_ctrl #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .out_empty(out_empty), .busy(busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference: find the maximum value, then the first position holding it
  function automatic void ref_model(input logic [7:0] q[$], output logic [7:0] m,
                                    output logic [3:0] ix);
    m = 0; ix = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    for (int i = q.size() - 1; i >= 0; i--) if (q[i] == m) ix = 4'(i);
  endfunction

  // Drives one job starting at the current negedge; returns captured result.
  // Gaps of gmin..gmax idle cycles precede each operand; spur pulses start
  // during gaps. rdy_err counts gap/accept cycles where in_ready/busy were wrong.
  task automatic drive_job(input int n, input logic [7:0] q[$], input int gmin,
                           input int gmax, input bit spur, output logic [7:0] om,
                           output logic [3:0] oi, output logic oe,
                           output int rdy_err, output bit late);
    int g;
    rdy_err = 0; late = 0;
    start = 1; len = 4'(n);
    @(negedge clk);
    start = 0; len = 0;
    for (int i = 0; i < n; i++) begin
      g = (gmax > 0) ? int'($urandom_range(gmax, gmin)) : 0;
      repeat (g) begin
        in_valid = 0;
        if (spur) begin start = 1; len = 0; end
        if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) rdy_err++;
        @(negedge clk);
        start = 0;
      end
      in_valid = 1; in_data = q[i];
      if (in_ready !== 1'b1) rdy_err++;
      @(negedge clk);
    end
    in_valid = 0; in_data = 8'($urandom);
    if (out_valid !== 1'b1) begin
      late = 1;
      for (int k = 0; k < 50 && out_valid !== 1'b1; k++) @(negedge clk);
    end
    om = out_max; oi = out_idx; oe = out_empty;
  endtask

  task automatic take_result();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, out_valid, out_max, out_idx, out_empty, busy} !== '0) begin
      bad++;
      $display("FAIL reset_hold: got rdy=%b vld=%b max=%0d idx=%0d emp=%b busy=%b want all 0",
               in_ready, out_valid, out_max, out_idx, out_empty, busy);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b busy=%b want 000", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q[$], om, em; logic [3:0] oi, ei; logic oe; int re, unstable; bit late;
    q = {8'd3, 8'd9, 8'd2, 8'd7};
    ref_model(q, em, ei);
    drive_job(4, q, 0, 0, 0, om, oi, oe, re, late);
    total++;
    if (late !== 1'b0) begin bad++; $display("FAIL basic_latency: out_valid late, want 1 cycle"); end
    total++;
    if ({om, oi, oe} !== {em, ei, 1'b0} || em !== 8'd9 || ei !== 4'd1) begin
      bad++; $display("FAIL basic_result: got max=%0d idx=%0d emp=%b want 9/1/0", om, oi, oe);
    end
    total++;
    if (re != 0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_ready: rdy errors=%0d in_ready_done=%b want 0/0", re, in_ready);
    end
    unstable = 0;
    repeat (5) begin
      @(negedge clk);
      if ({out_valid, busy, out_max, out_idx, out_empty} !== {2'b11, 8'd9, 4'd1, 1'b0}) unstable++;
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL basic_hold: %0d unstable cycles want 0", unstable); end
    take_result();
    total++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      bad++; $display("FAIL basic_take: got busy=%b vld=%b rdy=%b want 000", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_ties_gaps();
    logic [7:0] q[$], om; logic [3:0] oi; logic oe; int re; bit late;
    q = {8'd5, 8'd8, 8'd8, 8'd1, 8'd8};
    drive_job(5, q, 2, 2, 0, om, oi, oe, re, late);
    total++;
    if ({om, oi, oe, late} !== {8'd8, 4'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ties_result: got max=%0d idx=%0d emp=%b late=%b want 8/1/0/0", om, oi, oe, late);
    end
    total++;
    if (re != 0) begin bad++; $display("FAIL ties_gaps: %0d bad gap cycles want 0", re); end
    take_result();
  endtask

  task automatic test_bounds();
    logic [7:0] q[$], om; logic [3:0] oi; logic oe; int re; bit late;
    q = {};
    drive_job(0, q, 0, 0, 0, om, oi, oe, re, late);
    total++;
    if ({om, oi, oe, late, in_ready} !== {8'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL len0: got max=%0d idx=%0d emp=%b late=%b want 0/0/1/0", om, oi, oe, late);
    end
    take_result();
    total++;
    if ({out_empty, out_valid, busy} !== 3'b000) begin
      bad++; $display("FAIL len0_clear: got emp=%b vld=%b busy=%b want 000", out_empty, out_valid, busy);
    end
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(8'(i));
    drive_job(15, q, 0, 0, 0, om, oi, oe, re, late);
    total++;
    if ({om, oi, oe, late} !== {8'd14, 4'd14, 1'b0, 1'b0}) begin
      bad++; $display("FAIL len15_asc: got max=%0d idx=%0d emp=%b want 14/14/0", om, oi, oe);
    end
    take_result();
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(8'd255);
    drive_job(15, q, 0, 1, 0, om, oi, oe, re, late);
    total++;
    if ({om, oi, oe, late} !== {8'd255, 4'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL len15_255: got max=%0d idx=%0d emp=%b want 255/0/0", om, oi, oe);
    end
    take_result();
  endtask

  task automatic test_spurious();
    logic [7:0] q[$], om; logic [3:0] oi; logic oe; int re; bit late;
    q = {8'd2, 8'd7, 8'd5};
    drive_job(3, q, 1, 1, 1, om, oi, oe, re, late);
    total++;
    if ({om, oi, oe, late} !== {8'd7, 4'd1, 1'b0, 1'b0} || re != 0) begin
      bad++; $display("FAIL spur_run: got max=%0d idx=%0d emp=%b re=%0d want 7/1/0/0", om, oi, oe, re);
    end
    start = 1; len = 4'd0;
    @(negedge clk);
    start = 0;
    total++;
    if ({out_valid, out_max, out_idx, out_empty} !== {1'b1, 8'd7, 4'd1, 1'b0}) begin
      bad++; $display("FAIL spur_done: got vld=%b max=%0d idx=%0d emp=%b want 1/7/1/0",
                      out_valid, out_max, out_idx, out_empty);
    end
    take_result();
    q = {8'd1, 8'd200, 8'd3};
    drive_job(3, q, 0, 0, 0, om, oi, oe, re, late);
    total++;
    if ({om, oi, oe, late} !== {8'd200, 4'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL spur_next: got max=%0d idx=%0d emp=%b want 200/1/0", om, oi, oe);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$], om; logic [3:0] oi; logic oe; int re; bit late;
    start = 1; len = 4'd4;
    @(negedge clk);
    start = 0;
    in_valid = 1; in_data = 8'd50; @(negedge clk);
    in_data = 8'd90; @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({in_ready, out_valid, out_max, out_idx, out_empty, busy} !== '0) begin
      bad++; $display("FAIL reset_mid: got rdy=%b vld=%b max=%0d idx=%0d emp=%b busy=%b want all 0",
                      in_ready, out_valid, out_max, out_idx, out_empty, busy);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    q = {8'd4, 8'd6};
    drive_job(2, q, 0, 0, 0, om, oi, oe, re, late);
    total++;
    if ({om, oi, oe, late} !== {8'd6, 4'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_mid_next: got max=%0d idx=%0d emp=%b want 6/1/0", om, oi, oe);
    end
    take_result();
  endtask

  task automatic test_random();
    logic [7:0] q[$], om, em; logic [3:0] oi, ei; logic oe; int re, n, hold; bit late;
    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(15, 0);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(($urandom_range(1, 0) != 0) ? 8'($urandom_range(7, 0)) : 8'($urandom));
      ref_model(q, em, ei);
      drive_job(n, q, 0, 2, $urandom_range(1, 0) != 0, om, oi, oe, re, late);
      total++;
      if ({om, oi, oe, late} !== {em, ei, (n == 0), 1'b0} || re != 0) begin
        bad++; $display("FAIL rand_job%0d: len=%0d got max=%0d idx=%0d emp=%b late=%b re=%0d want %0d/%0d/%b",
                        j, n, om, oi, oe, late, re, em, ei, (n == 0));
      end
      hold = $urandom_range(3, 0);
      repeat (hold) @(negedge clk);
      take_result();
      total++;
      if ({busy, out_valid, out_empty} !== 3'b000) begin
        bad++; $display("FAIL rand_take%0d: got busy=%b vld=%b emp=%b want 000", j, busy, out_valid, out_empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_gaps();
    test_bounds();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
